// File: rtl/gate_seq_ctrl.sv
// Control sequencer for one LSTM gate pre-activation (Wx*x + Wh*h + b) on a shared
// mult/add-tree/accumulator datapath, with a ready/valid result register.
module gate_seq_ctrl #(
   parameter int WL       = 16,
   parameter int PIPE_LAT = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_valid,
   output logic          start_ready,
   output logic          mux_mult_sel,
   output logic          mux_acc_sel,
   output logic          accum_rst,
   input  logic [WL-1:0] gate_out,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [WL-1:0] result
);

   localparam int CW = $clog2(PIPE_LAT + 5);

   localparam logic [CW-1:0] K_ISSUE_H = CW'(2);
   localparam logic [CW-1:0] K_ACC_X   = CW'(PIPE_LAT + 1);
   localparam logic [CW-1:0] K_ACC_H   = CW'(PIPE_LAT + 2);
   localparam logic [CW-1:0] K_ACC_B   = CW'(PIPE_LAT + 3);
   localparam logic [CW-1:0] K_CAPTURE = CW'(PIPE_LAT + 4);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE_X,
      S_ISSUE_H,
      S_WAIT,
      S_ACC_X,
      S_ACC_H,
      S_ACC_B,
      S_CAPTURE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mux_mult_sel_q, mux_mult_sel_d;
   logic          mux_acc_sel_q, mux_acc_sel_d;
   logic          accum_rst_q, accum_rst_d;
   logic          out_valid_q, out_valid_d;
   logic [WL-1:0] result_q, result_d;
   logic          accept;
   logic          capture;

   // The counter holds the cycle index k since acceptance (0 when idle); every registered
   // control output is decoded from the next index so it is valid during cycle k itself.
   always_comb begin
      start_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
      accept      = start_valid && start_ready;
      capture     = (state_q == S_CAPTURE);

      cnt_d = cnt_q;
      if (accept)                  cnt_d = CW'(1);
      else if (capture)            cnt_d = '0;
      else if (state_q != S_IDLE)  cnt_d = cnt_q + CW'(1);

      // ACC decodes take priority so that with PIPE_LAT = 1 cycle 2 is ACC_X, while
      // mux_mult_sel is decoded from the index alone and still issues the h operands.
      state_d = S_WAIT;
      if (cnt_d == '0)              state_d = S_IDLE;
      else if (cnt_d == K_CAPTURE)  state_d = S_CAPTURE;
      else if (cnt_d == K_ACC_B)    state_d = S_ACC_B;
      else if (cnt_d == K_ACC_H)    state_d = S_ACC_H;
      else if (cnt_d == K_ACC_X)    state_d = S_ACC_X;
      else if (cnt_d == CW'(1))     state_d = S_ISSUE_X;
      else if (cnt_d == K_ISSUE_H)  state_d = S_ISSUE_H;

      mux_mult_sel_d = (cnt_d == K_ISSUE_H);
      mux_acc_sel_d  = (state_d == S_ACC_B);
      accum_rst_d    = !((state_d == S_ACC_X) || (state_d == S_ACC_H) || (state_d == S_ACC_B));

      out_valid_d = out_valid_q;
      if (capture)        out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;

      result_d = capture ? gate_out : result_q;
   end

   // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         mux_mult_sel_q <= 1'b0;
         mux_acc_sel_q  <= 1'b0;
         accum_rst_q    <= 1'b1;
         out_valid_q    <= 1'b0;
         result_q       <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         mux_mult_sel_q <= mux_mult_sel_d;
         mux_acc_sel_q  <= mux_acc_sel_d;
         accum_rst_q    <= accum_rst_d;
         out_valid_q    <= out_valid_d;
         result_q       <= result_d;
      end
   end

   assign mux_mult_sel = mux_mult_sel_q;
   assign mux_acc_sel  = mux_acc_sel_q;
   assign accum_rst    = accum_rst_q;
   assign busy         = (state_q != S_IDLE);
   assign out_valid    = out_valid_q;
   assign result       = result_q;

endmodule
